odd_seq_checker: RTL and testbench

Receive-side monitor for the odd-number counter stream. Samples an up-counting odd sequence (1, 3, 5, … 255, 1, …), acquires lock after a run of consecutive correct samples, then flags and counts every sequence violation. Sits downstream of the odd counter in self-checking benches and on-chip BIST paths, one clock domain.

---
 rtl/odd_cnt_pkg.sv | 13 +
 rtl/odd_seq_checker_if.sv | 22 ++
 rtl/odd_seq_checker_sat_counter.sv | 19 +
 rtl/odd_seq_checker.sv | 114 +++++++++++
 tb/tb_odd_seq_checker.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/odd_cnt_pkg.sv
// Shared definitions for the odd-number counter and its receive-side checker.
package odd_cnt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACQ    = 2'b01,
    LOCKED = 2'b10
  } state_e;

  localparam int STEP          = 2;
  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/odd_seq_checker_if.sv
// Sample stream in, lock/error status out, for the odd sequence checker.
interface odd_seq_checker_if #(
  parameter int WIDTH = 8,
  parameter int ERR_W = 8
);
  logic             valid_i;
  logic [WIDTH-1:0] cnt_i;
  logic             locked_o;
  logic             err_o;
  logic [ERR_W-1:0] err_cnt_o;
  logic [WIDTH-1:0] exp_o;

  modport master (
    output valid_i, cnt_i,
    input  locked_o, err_o, err_cnt_o, exp_o
  );

  modport slave (
    input  valid_i, cnt_i,
    output locked_o, err_o, err_cnt_o, exp_o
  );
endinterface

// File: rtl/odd_seq_checker_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/odd_seq_checker.sv
// Odd-sequence monitor: acquires lock on 1,3,5,... and counts violations seen while locked.
//
// state  | meaning
// IDLE   | not tracking, waiting for an odd sample
// ACQ    | tracking, counting consecutive +2 steps toward lock
// LOCKED | locked, any mismatch is a counted violation
module odd_seq_checker
  import odd_cnt_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int LOCK_RUN = 2,
  parameter int ERR_W    = 8
) (
  input logic               clk,
  input logic               rst,
  odd_seq_checker_if.slave  bus
);

  state_e           state_q, state_d;
  logic [3:0]       run_q, run_d, run_inc;
  logic [WIDTH-1:0] exp_q, exp_d, next_exp;
  logic             locked_q, err_q, err_d;
  logic             match, odd;

  assign next_exp = bus.cnt_i + WIDTH'(STEP);
  assign run_inc  = run_q + 4'd1;
  assign match    = (bus.cnt_i == exp_q);
  assign odd      = bus.cnt_i[0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      run_q    <= '0;
      exp_q    <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      exp_q    <= exp_d;
      locked_q <= (state_d == LOCKED);
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    exp_d   = exp_q;
    err_d   = 1'b0;
    if (bus.valid_i) begin
      case (state_q)
        IDLE: begin
          if (odd) begin
            state_d = ACQ;
            run_d   = '0;
            exp_d   = next_exp;
          end
        end
        ACQ: begin
          if (match) begin
            exp_d = next_exp;
            if (run_inc == 4'(LOCK_RUN)) begin
              state_d = LOCKED;
              run_d   = '0;
            end else begin
              run_d = run_inc;
            end
          end else if (odd) begin
            run_d = '0;
            exp_d = next_exp;
          end else begin
            state_d = IDLE;
            run_d   = '0;
            exp_d   = '0;
          end
        end
        LOCKED: begin
          if (match) begin
            exp_d = next_exp;
          end else begin
            err_d = 1'b1;
            run_d = '0;
            if (odd) begin
              state_d = ACQ;
              exp_d   = next_exp;
            end else begin
              state_d = IDLE;
              exp_d   = '0;
            end
          end
        end
        default: begin
          state_d = IDLE;
          run_d   = '0;
          exp_d   = '0;
        end
      endcase
    end
  end

  // err_d feeds the counter directly so the count moves on the same edge err_o rises
  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_d),
    .count (bus.err_cnt_o)
  );

  assign bus.locked_o = locked_q;
  assign bus.err_o    = err_q;
  assign bus.exp_o    = exp_q;

endmodule

// File: tb/tb_odd_seq_checker.sv
// Directed bench: dut_a uses an 8-bit error counter, dut_b a 2-bit one; both see the same stream.
module tb_odd_seq_checker;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] cnt = 8'd0;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  odd_seq_checker_if #(.WIDTH(8), .ERR_W(8)) a_if ();
  odd_seq_checker_if #(.WIDTH(8), .ERR_W(2)) b_if ();

  assign a_if.valid_i = valid;
  assign a_if.cnt_i   = cnt;
  assign b_if.valid_i = valid;
  assign b_if.cnt_i   = cnt;

  odd_seq_checker #(.WIDTH(8), .LOCK_RUN(2), .ERR_W(8)) dut_a (
    .clk (clk), .rst (rst), .bus (a_if.slave)
  );
  odd_seq_checker #(.WIDTH(8), .LOCK_RUN(2), .ERR_W(2)) dut_b (
    .clk (clk), .rst (rst), .bus (b_if.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] c);
    valid = v;
    cnt   = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b0;
    valid = 1'b1;
    cnt   = 8'd5;
    @(posedge clk);
    #1;
    rst   = 1'b1;
    valid = 1'b0;
  endtask

  task automatic chk_a(input string tag, input logic lk, input logic er,
                       input logic [7:0] ec, input logic [7:0] ex);
    chk({tag, "_locked"}, 32'(a_if.locked_o), 32'(lk));
    chk({tag, "_err"},    32'(a_if.err_o),    32'(er));
    chk({tag, "_errcnt"}, 32'(a_if.err_cnt_o), 32'(ec));
    chk({tag, "_exp"},    32'(a_if.exp_o),    32'(ex));
  endtask

  initial begin
    // reset holds everything at zero even with valid high
    do_reset();
    chk_a("rst", 1'b0, 1'b0, 8'd0, 8'd0);
    chk("rst_b_errcnt", 32'(b_if.err_cnt_o), 32'd0);

    // basic acquisition 1,3,5,7
    drive(1'b1, 8'd1); chk_a("s1", 1'b0, 1'b0, 8'd0, 8'd3);
    drive(1'b1, 8'd3); chk_a("s3", 1'b0, 1'b0, 8'd0, 8'd5);
    drive(1'b1, 8'd5); chk_a("s5", 1'b1, 1'b0, 8'd0, 8'd7);
    drive(1'b1, 8'd7); chk_a("s7", 1'b1, 1'b0, 8'd0, 8'd9);

    // wrap 255 -> 1 while locked
    do_reset();
    drive(1'b1, 8'd249); chk_a("w249", 1'b0, 1'b0, 8'd0, 8'd251);
    drive(1'b1, 8'd251);
    drive(1'b1, 8'd253); chk_a("w253", 1'b1, 1'b0, 8'd0, 8'd255);
    drive(1'b1, 8'd255); chk_a("w255", 1'b1, 1'b0, 8'd0, 8'd1);
    drive(1'b1, 8'd1);   chk_a("w1",   1'b1, 1'b0, 8'd0, 8'd3);
    drive(1'b1, 8'd3);   chk_a("w3",   1'b1, 1'b0, 8'd0, 8'd5);

    // odd violation while locked, then relock
    do_reset();
    drive(1'b1, 8'd5);
    drive(1'b1, 8'd7);
    drive(1'b1, 8'd9);  chk_a("v9",  1'b1, 1'b0, 8'd0, 8'd11);
    drive(1'b1, 8'd15); chk_a("v15", 1'b0, 1'b1, 8'd1, 8'd17);
    drive(1'b1, 8'd17); chk_a("v17", 1'b0, 1'b0, 8'd1, 8'd19);
    drive(1'b1, 8'd19); chk_a("v19", 1'b1, 1'b0, 8'd1, 8'd21);
    drive(1'b1, 8'd21); chk_a("v21", 1'b1, 1'b0, 8'd1, 8'd23);

    // even values in IDLE are ignored silently
    do_reset();
    drive(1'b1, 8'd0); chk_a("e0", 1'b0, 1'b0, 8'd0, 8'd0);
    drive(1'b1, 8'd2); chk_a("e2", 1'b0, 1'b0, 8'd0, 8'd0);
    drive(1'b1, 8'd4); chk_a("e4", 1'b0, 1'b0, 8'd0, 8'd0);
    drive(1'b1, 8'd1); chk_a("e1", 1'b0, 1'b0, 8'd0, 8'd3);
    drive(1'b1, 8'd3);
    drive(1'b1, 8'd5); chk_a("e5", 1'b1, 1'b0, 8'd0, 8'd7);

    // ACQ restart on odd mismatch, drop to IDLE on even mismatch, no errors
    drive(1'b0, 8'd0);
    do_reset();
    drive(1'b1, 8'd1);
    drive(1'b1, 8'd3);
    drive(1'b1, 8'd21); chk_a("r21", 1'b0, 1'b0, 8'd0, 8'd23);
    drive(1'b1, 8'd23); chk_a("r23", 1'b0, 1'b0, 8'd0, 8'd25);
    drive(1'b1, 8'd40); chk_a("r40", 1'b0, 1'b0, 8'd0, 8'd0);
    drive(1'b1, 8'd1);
    drive(1'b1, 8'd3);
    drive(1'b1, 8'd5);  chk_a("r5", 1'b1, 1'b0, 8'd0, 8'd7);

    // valid gap while locked holds exp_o
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 8'd99);
      chk_a("gap", 1'b1, 1'b0, 8'd0, 8'd7);
    end
    drive(1'b1, 8'd7); chk_a("gap_resume", 1'b1, 1'b0, 8'd0, 8'd9);

    // even violation while locked goes to IDLE and counts
    drive(1'b1, 8'd8);  chk_a("ev8", 1'b0, 1'b1, 8'd1, 8'd0);
    drive(1'b0, 8'd0);  chk_a("ev_after", 1'b0, 1'b0, 8'd1, 8'd0);

    // saturation: dut_b holds at 3, dut_a keeps counting
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 8'd1);
      chk("sat_err_quiet", 32'(b_if.err_o), 32'd0);
      drive(1'b1, 8'd3);
      drive(1'b1, 8'd5);
      chk("sat_locked", 32'(b_if.locked_o), 32'd1);
      drive(1'b1, 8'd100);
      chk("sat_b_err", 32'(b_if.err_o), 32'd1);
      chk("sat_b_cnt", 32'(b_if.err_cnt_o), (k < 3) ? 32'(k) : 32'd3);
      chk("sat_a_cnt", 32'(a_if.err_cnt_o), 32'(k));
    end

    // reset mid-stream with valid high
    drive(1'b1, 8'd1);
    drive(1'b1, 8'd3);
    do_reset();
    chk_a("mrst", 1'b0, 1'b0, 8'd0, 8'd0);
    chk("mrst_b_cnt", 32'(b_if.err_cnt_o), 32'd0);
    chk("mrst_b_locked", 32'(b_if.locked_o), 32'd0);
    drive(1'b1, 8'd7);  chk_a("mrst7", 1'b0, 1'b0, 8'd0, 8'd9);
    drive(1'b1, 8'd9);  chk_a("mrst9", 1'b0, 1'b0, 8'd0, 8'd11);
    drive(1'b1, 8'd11); chk_a("mrst11", 1'b1, 1'b0, 8'd0, 8'd13);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
